avalon_pio_gen2: RTL and testbench

Parametrised Avalon-MM slave general-purpose I/O port, successor to the single-register output PIO. Provides:
- per-bit direction
- atomic set/clear writes
- synchronised inputs with edge capture and a maskable level interrupt
- per-bit hardware blink driven by a programmable prescaler

Sits on the system interconnect between the Nios II data master and board LEDs, switches and keys.

---
 rtl/avalon_pio_pkg.sv | 23 ++
 rtl/pio_blink_prescaler.sv | 40 ++++
 rtl/avalon_pio_gen2.sv | 154 +++++++++++++++
 tb/tb_avalon_pio_gen2.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// Purpose : shared register map and edge-mode constants for the Avalon PIO gen2 slave.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package avalon_pio_pkg;

  // Word addresses of the slave registers.
  typedef enum logic [2:0] {
    ADDR_DATA         = 3'd0,
    ADDR_DIR          = 3'd1,
    ADDR_IRQ_MASK     = 3'd2,
    ADDR_EDGE_CAP     = 3'd3,
    ADDR_OUTSET       = 3'd4,
    ADDR_OUTCLR       = 3'd5,
    ADDR_BLINK_EN     = 3'd6,
    ADDR_BLINK_PERIOD = 3'd7
  } pio_addr_e;

  // Edge detection modes for the input capture path.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_blink_prescaler.sv
// Purpose : down-counting prescaler producing the blink phase for the PIO outputs.
// Latency : phase changes on the clk edge where the counter wraps; a load forces phase high on the next edge.
// Backpressure: none, free-running whenever period is non-zero.
//
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   period       : reload value; half-period of the blink is period+1 clks, 0 stops the counter
//   load         : reload the counter from period and restart the phase high
//   phase        : current blink phase (1 = output visible)
module pio_blink_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  load,
  output logic                  phase
);

  logic [PRESCALE_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (load) begin
      // A reload takes priority over a coincident wrap, so a period write never toggles.
      cnt   <= period;
      phase <= 1'b1;
    end else if (period == '0) begin
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt   <= period;
      phase <= ~phase;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/avalon_pio_gen2.sv
// Purpose : Avalon-MM GPIO slave with direction, set/clear, edge capture IRQ and hardware blink.
// Latency : zero-wait-state reads (combinational readdata); writes land on the next clk; input edges reach edge_cap 3 clks after sampling.
// Backpressure: none, the slave accepts every access immediately.
//
// Ports:
//   clk, reset_n                   : system clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata            : Avalon-MM slave port (word addressed, 8 registers)
//   in_port                        : external inputs, asynchronous to clk
//   out_port, oe                   : driven output value and per-bit output enable
//   irq                            : level interrupt, active high
module avalon_pio_gen2
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 9,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '1,
  parameter int               EDGE_TYPE   = 0,
  parameter int               PRESCALE_W  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0]      data_out;
  logic [WIDTH-1:0]      dir;
  logic [WIDTH-1:0]      irq_mask;
  logic [WIDTH-1:0]      edge_cap;
  logic [WIDTH-1:0]      blink_en;
  logic [PRESCALE_W-1:0] blink_period;

  logic [WIDTH-1:0]      in_s1;
  logic [WIDTH-1:0]      in_sync;
  logic [WIDTH-1:0]      in_d;
  logic [WIDTH-1:0]      in_edge;
  logic                  irq_r;

  logic                  wr_en;
  logic [WIDTH-1:0]      wd;
  logic [PRESCALE_W-1:0] wd_period;
  logic                  period_load;
  logic [PRESCALE_W-1:0] period_next;
  logic                  blink_phase;

  // Bits of writedata above the register widths are intentionally dropped.
  logic                  unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en       = chipselect && !write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign wd_period   = writedata[PRESCALE_W-1:0];
  assign period_load = wr_en && (address == ADDR_BLINK_PERIOD);

  // The prescaler must reload with the value being written, not the stale register.
  assign period_next = period_load ? wd_period : blink_period;

  // Synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_s1   <= '0;
      in_sync <= '0;
      in_d    <= '0;
    end else begin
      in_s1   <= in_port;
      in_sync <= in_s1;
      in_d    <= in_sync;
    end
  end

  always_comb begin
    in_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISE: in_edge = in_sync & ~in_d;
      EDGE_FALL: in_edge = ~in_sync & in_d;
      default:   in_edge = (in_sync & ~in_d) | (~in_sync & in_d);
    endcase
  end

  // Register file. Edge capture is handled here too so the W1C and the set share one update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= RESET_VALUE;
      dir          <= RESET_DIR;
      irq_mask     <= '0;
      edge_cap     <= '0;
      blink_en     <= '0;
      blink_period <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:         data_out     <= wd;
          ADDR_DIR:          dir          <= wd;
          ADDR_IRQ_MASK:     irq_mask     <= wd;
          ADDR_OUTSET:       data_out     <= data_out | wd;
          ADDR_OUTCLR:       data_out     <= data_out & ~wd;
          ADDR_BLINK_EN:     blink_en     <= wd;
          ADDR_BLINK_PERIOD: blink_period <= wd_period;
          default:           ;
        endcase
      end
      // Set wins over a coincident clear; output bits never capture.
      if (wr_en && (address == ADDR_EDGE_CAP)) begin
        edge_cap <= (edge_cap & ~wd) | (in_edge & ~dir);
      end else begin
        edge_cap <= edge_cap | (in_edge & ~dir);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(edge_cap & irq_mask);
    end
  end

  pio_blink_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_next),
    .load    (period_load),
    .phase   (blink_phase)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:         readdata[WIDTH-1:0]      = (data_out & dir) | (in_sync & ~dir);
      ADDR_DIR:          readdata[WIDTH-1:0]      = dir;
      ADDR_IRQ_MASK:     readdata[WIDTH-1:0]      = irq_mask;
      ADDR_EDGE_CAP:     readdata[WIDTH-1:0]      = edge_cap;
      ADDR_BLINK_EN:     readdata[WIDTH-1:0]      = blink_en;
      ADDR_BLINK_PERIOD: readdata[PRESCALE_W-1:0] = blink_period;
      default:           readdata                 = '0;
    endcase
  end

  assign out_port = data_out & dir & (~blink_en | {WIDTH{blink_phase}});
  assign oe       = dir;
  assign irq      = irq_r;

endmodule

// File: tb/tb_avalon_pio_gen2.sv
module tb_avalon_pio_gen2;
  import avalon_pio_pkg::*;

  localparam int WIDTH = 9;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port = '0;
  logic [WIDTH-1:0] out_port;
  logic [WIDTH-1:0] oe;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  avalon_pio_gen2 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", obs, 32'hDEAD_BEEF);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Caller sits just after a negedge; the write lands on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
    sb_push(tag, e);
    address = a;
    #1;
    sb_pop(readdata);
  endtask

  task automatic out_chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    sb_push(tag, e);
    sb_pop(obs);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset values
    @(negedge clk);
    out_chk("rst_out_port", 32'(out_port), 32'h000);
    out_chk("rst_oe",       32'(oe),       32'h1FF);
    out_chk("rst_irq",      32'(irq),      32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(ADDR_DATA,         32'h000, "rst_data");
    rd(ADDR_DIR,          32'h1FF, "rst_dir");
    rd(ADDR_IRQ_MASK,     32'h000, "rst_irq_mask");
    rd(ADDR_EDGE_CAP,     32'h000, "rst_edge_cap");
    rd(ADDR_OUTSET,       32'h000, "rst_outset");
    rd(ADDR_OUTCLR,       32'h000, "rst_outclr");
    rd(ADDR_BLINK_EN,     32'h000, "rst_blink_en");
    rd(ADDR_BLINK_PERIOD, 32'h000, "rst_blink_period");
    @(negedge clk);

    // 2. Data, set and clear
    wr(ADDR_DATA,   32'h0F0);
    wr(ADDR_OUTSET, 32'h003);
    wr(ADDR_OUTCLR, 32'h010);
    rd(ADDR_DATA,   32'h0E3, "setclr_data");
    out_chk("setclr_out_port", 32'(out_port), 32'h0E3);
    rd(ADDR_OUTSET, 32'h000, "outset_reads_0");
    rd(ADDR_OUTCLR, 32'h000, "outclr_reads_0");
    @(negedge clk);

    // 3. Edge capture, irq, W1C and set-wins
    wr(ADDR_DIR,      32'h0FF);
    wr(ADDR_IRQ_MASK, 32'h100);
    out_chk("dir_out_port", 32'(out_port), 32'h0E3);
    in_port = 9'h100;
    cycles(2);
    rd(ADDR_EDGE_CAP, 32'h000, "edge_not_yet");
    @(negedge clk);
    rd(ADDR_EDGE_CAP, 32'h100, "edge_captured");
    out_chk("irq_not_yet", 32'(irq), 32'h0);
    rd(ADDR_DATA, 32'h1E3, "data_mixed_read");
    @(negedge clk);
    out_chk("irq_set", 32'(irq), 32'h1);
    wr(ADDR_EDGE_CAP, 32'h100);
    rd(ADDR_EDGE_CAP, 32'h000, "w1c_clear");
    out_chk("irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    out_chk("irq_cleared", 32'(irq), 32'h0);
    in_port = 9'h000;
    cycles(3);
    rd(ADDR_EDGE_CAP, 32'h000, "fall_ignored");
    @(negedge clk);
    in_port = 9'h100;
    cycles(2);
    wr(ADDR_EDGE_CAP, 32'h100);   // lands on the same edge as the capture
    rd(ADDR_EDGE_CAP, 32'h100, "set_wins");
    @(negedge clk);
    out_chk("irq_set_wins", 32'(irq), 32'h1);
    wr(ADDR_IRQ_MASK, 32'h000);
    @(negedge clk);
    out_chk("irq_masked", 32'(irq), 32'h0);
    wr(ADDR_IRQ_MASK, 32'h100);
    @(negedge clk);
    out_chk("irq_unmasked", 32'(irq), 32'h1);
    wr(ADDR_EDGE_CAP, 32'h100);
    rd(ADDR_EDGE_CAP, 32'h000, "w1c_again");
    @(negedge clk);

    // 4. Blink
    wr(ADDR_BLINK_EN, 32'h001);
    wr(ADDR_DATA,     32'h001);
    out_chk("blink_idle_high", 32'(out_port), 32'h001);
    wr(ADDR_BLINK_PERIOD, 32'd3);
    for (int k = 0; k < 16; k++) begin
      sb_push($sformatf("blink_k%0d", k), ((k / 4) % 2 == 0) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 16; k++) begin
      sb_pop(32'(out_port));
      @(negedge clk);
    end
    wr(ADDR_BLINK_PERIOD, 32'd0);
    for (int k = 0; k < 6; k++) sb_push($sformatf("blink_off_k%0d", k), 32'h1);
    for (int k = 0; k < 6; k++) begin
      sb_pop(32'(out_port));
      @(negedge clk);
    end

    // 5. Reset mid-blink with a pending edge
    in_port = 9'h000;
    cycles(3);
    in_port = 9'h100;
    cycles(4);
    rd(ADDR_EDGE_CAP, 32'h100, "pre_rst_edge");
    out_chk("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge clk);
    wr(ADDR_BLINK_PERIOD, 32'd3);
    cycles(5);
    out_chk("pre_rst_blink_low", 32'(out_port), 32'h000);
    #3;
    reset_n = 1'b0;
    #1;
    out_chk("arst_out_port", 32'(out_port), 32'h000);
    out_chk("arst_irq",      32'(irq),      32'h0);
    out_chk("arst_oe",       32'(oe),       32'h1FF);
    rd(ADDR_EDGE_CAP, 32'h000, "arst_edge_cap");
    @(negedge clk);
    reset_n = 1'b1;
    rd(ADDR_BLINK_PERIOD, 32'h000, "post_rst_period");
    rd(ADDR_BLINK_EN,     32'h000, "post_rst_blink_en");
    @(negedge clk);
    wr(ADDR_BLINK_EN, 32'h001);
    wr(ADDR_DATA,     32'h001);
    for (int k = 0; k < 4; k++) sb_push($sformatf("post_rst_phase_k%0d", k), 32'h1);
    for (int k = 0; k < 4; k++) begin
      sb_pop(32'(out_port));
      @(negedge clk);
    end

    // 6. Over-wide writes
    wr(ADDR_DATA,     32'hFFFF_FFFF);
    wr(ADDR_DIR,      32'hFFFF_FFFF);
    wr(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
    rd(ADDR_DATA,     32'h0000_01FF, "wide_data");
    rd(ADDR_DIR,      32'h0000_01FF, "wide_dir");
    rd(ADDR_IRQ_MASK, 32'h0000_01FF, "wide_irq_mask");
    @(negedge clk);
    wr(ADDR_BLINK_PERIOD, 32'hFFFF_FFFF);
    rd(ADDR_BLINK_PERIOD, 32'h00FF_FFFF, "wide_period");
    out_chk("wide_out_port", 32'(out_port), 32'h1FF);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
